nonce_reporter: RTL and testbench
=================================

NONCE_REPORTER -- requirements
Module: nonce_reporter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of golden nonces buffered; it is a power of two, from 2 to 16.
REQ-002 SHALL have parameter MSG_NONCE_FOUND, default 8'd6, meaning the message-type byte placed in every emitted packet.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge; all logic sits in this domain.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx_new_nonce, input, 1 bit: one-cycle strobe qualifying rx_golden_nonce.
REQ-006 SHALL have port rx_golden_nonce, input, 32 bits: the found nonce.
REQ-007 SHALL have port tx_valid, output, 1 bit: tx_byte holds a packet byte.
REQ-008 SHALL have port tx_byte, output, 8 bits: the outgoing packet byte toward the UART TX path.
REQ-009 SHALL have port tx_ready, input, 1 bit: the consumer accepts tx_byte this cycle.
REQ-010 SHALL have port fifo_level, output, 5 bits: the number of nonces currently queued, not counting the one being sent.
REQ-011 SHALL have port overflow_count, output, 8 bits: the number of nonces dropped, saturating.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-013 SHALL emit each packet as 12 bytes, in order: 8'h0C, 8'h00, 8'h00, MSG_NONCE_FOUND, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24], crc[7:0], crc[15:8], crc[23:16], crc[31:24].
REQ-014 SHALL compute crc as a reflected CRC-32 over bytes 0..7:
- polynomial 0xEDB88320, initial value 0xFFFFFFFF, no final XOR;
- byte 0 is processed first;
- the receiver's residue over all 12 bytes is therefore 32'd0.
REQ-015 SHALL transfer a byte only on a clk edge where tx_valid and tx_ready are both high.
REQ-016 SHALL hold tx_byte and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-017 SHALL keep tx_valid high with no gaps from byte 0 through byte 11 of a packet.
REQ-018 SHALL implement FSM states IDLE, SEND and CRC with these transitions:
- IDLE→SEND when the FIFO is non-empty; this pops one nonce into a 32-bit holding register, resets the CRC to 0xFFFFFFFF and sets the byte index to 0;
- SEND→CRC after byte 7 transfers;
- CRC→IDLE after byte 11 transfers.
REQ-019 SHALL update the CRC in SEND on each transferred byte, one byte per cycle, and freeze it in CRC.
REQ-020 SHALL raise tx_valid in the cycle following the IDLE pop.
- Minimum latency: rx_new_nonce sampled at edge k gives tx_valid=1 after edge k+1.
REQ-021 SHALL have an inter-packet gap of exactly one IDLE cycle when the FIFO is non-empty.
REQ-022 SHALL, when rx_new_nonce=1 and the FIFO is not full, write rx_golden_nonce at the FIFO tail.
REQ-023 SHALL, when rx_new_nonce=1, the FIFO is full and no pop occurs that cycle, drop the nonce and increment overflow_count, saturating at 8'hFF.
REQ-024 SHALL, on a simultaneous push and pop while full, accept the push; fifo_level is unchanged.
REQ-025 SHALL, on a simultaneous push and pop while the FIFO holds one entry, pop the old entry and store the new one; fifo_level remains 1.
REQ-026 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
REQ-027 SHALL leave the packet in progress unaffected by FIFO pushes.
REQ-028 SHALL let the FIFO drain in arrival order (FIFO order).

Reset
REQ-029 SHALL, when reset_n=0, immediately force these values without waiting for clk:
- FSM=IDLE, tx_valid=0, tx_byte=8'h00, busy=0;
- fifo_level=0, FIFO pointers=0, overflow_count=0, CRC=0xFFFFFFFF.
REQ-030 SHALL, if reset occurs mid-packet, abandon the packet; after release, no partial packet bytes are emitted and queued nonces are lost.
REQ-031 SHALL leave the FSM in IDLE on the first edge after reset_n rises and accept rx_new_nonce on that edge.

Verification
REQ-032 Single nonce, tx_ready tied 1: rx_golden_nonce=32'h12345678 strobed → tx_byte sequence 0C 00 00 06 78 56 34 12 followed by 4 CRC bytes; the CRC-32 residue over all 12 bytes equals 0, and tx_valid is high for exactly 12 consecutive cycles.
REQ-033 Backpressure: tx_ready random at 30% duty → same 12 bytes in order; tx_byte never changes while tx_valid=1 and tx_ready=0.
REQ-034 Overflow, FIFO_DEPTH=4, tx_ready=0: 6 nonces strobed → one nonce held in the packet, fifo_level=4, overflow_count=1; release tx_ready → 5 packets in arrival order; then 300 strobes while stalled → overflow_count=8'hFF.
REQ-035 Back-to-back: 3 nonces on consecutive cycles, tx_ready=1 → 3 packets, each separated by exactly one tx_valid=0 cycle; fifo_level ends at 0.
REQ-036 Reset mid-packet: reset_n pulsed low after byte 5 transfers with 2 nonces queued → tx_valid=0 immediately, fifo_level=0; after release with no new strobes, no bytes emitted for 50 cycles.

Source files
------------

// File: rtl/nonce_reporter.sv
// Purpose: queue found nonces and emit each one as a 12-byte framed packet ending in a CRC-32.
// Latency: a nonce strobed into an empty, idle block is presented on tx_valid one cycle later.
// Backpressure: tx_byte/tx_valid hold while tx_ready is low; a strobe into a full queue with no pop is dropped and counted.
module nonce_reporter #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [7:0]  MSG_NONCE_FOUND = 8'd6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_new_nonce,
  input  logic [31:0] rx_golden_nonce,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic [4:0]  fifo_level,
  output logic [7:0]  overflow_count,
  output logic        busy
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CRC  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    count_q, count_d;
  logic [7:0]    ovf_q;
  logic [31:0]   hold_q;
  logic [31:0]   crc_q;
  logic [3:0]    idx_q;

  logic full, empty, pop, push, drop, xfer;

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign full  = (count_q == DEPTH_L);
  assign empty = (count_q == 5'd0);
  // A pop happens only from IDLE, so a push never collides with the packet being sent.
  assign pop   = (state_q == IDLE) && !empty;
  assign push  = rx_new_nonce && (!full || pop);
  assign drop  = rx_new_nonce && full && !pop;
  assign xfer  = tx_valid && tx_ready;

  assign tx_valid       = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign fifo_level     = count_q;
  assign overflow_count = ovf_q;
  assign count_d        = count_q + 5'(push) - 5'(pop);

  // Next-state logic: IDLE pops, SEND covers bytes 0..7, CRC covers bytes 8..11.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SEND;
      SEND:    if (xfer && idx_q == 4'd7) state_d = CRC;
      CRC:     if (xfer && idx_q == 4'd11) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte mux: header, nonce little-endian, then CRC little-endian; zero when idle.
  always_comb begin
    tx_byte = 8'h00;
    if (state_q != IDLE) begin
      case (idx_q)
        4'd0:    tx_byte = 8'h0C;
        4'd1:    tx_byte = 8'h00;
        4'd2:    tx_byte = 8'h00;
        4'd3:    tx_byte = MSG_NONCE_FOUND;
        4'd4:    tx_byte = hold_q[7:0];
        4'd5:    tx_byte = hold_q[15:8];
        4'd6:    tx_byte = hold_q[23:16];
        4'd7:    tx_byte = hold_q[31:24];
        4'd8:    tx_byte = crc_q[7:0];
        4'd9:    tx_byte = crc_q[15:8];
        4'd10:   tx_byte = crc_q[23:16];
        4'd11:   tx_byte = crc_q[31:24];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FIFO storage; contents need no reset because the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_golden_nonce;
  end

  // FIFO pointers, level and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
    end
  end

  // Packet datapath: latch the nonce on pop, step byte index on each transfer, accumulate CRC over bytes 0..7.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 32'h0;
      crc_q  <= 32'hFFFFFFFF;
      idx_q  <= 4'd0;
    end else if (pop) begin
      hold_q <= mem_q[rd_ptr_q];
      crc_q  <= 32'hFFFFFFFF;
      idx_q  <= 4'd0;
    end else if (xfer) begin
      idx_q <= idx_q + 4'd1;
      if (state_q == SEND) crc_q <= crc_byte(crc_q, tx_byte);
    end
  end

endmodule

// File: tb/tb_nonce_reporter.sv
// Purpose: randomized scoreboard bench for nonce_reporter against a packet-level reference model.
// Latency: expected bytes are queued at strobe time and consumed by a negedge monitor on each handshake.
// Backpressure: tx_ready driven low, high or 30% random; the monitor checks hold-stability and gapless packets.
module tb_nonce_reporter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_new_nonce = 1'b0;
  logic [31:0] rx_golden_nonce = 32'h0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic [4:0]  fifo_level;
  logic [7:0]  overflow_count;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0 = stalled, 1 = always ready, 2 = 30% random
  logic [7:0] exp_q[$];
  int start_q[$];
  int end_q[$];

  nonce_reporter #(.FIFO_DEPTH(DEPTH), .MSG_NONCE_FOUND(8'd6)) dut (
    .clk(clk), .reset_n(reset_n), .rx_new_nonce(rx_new_nonce), .rx_golden_nonce(rx_golden_nonce),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready), .fifo_level(fifo_level),
    .overflow_count(overflow_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the full 12-byte packet for one accepted nonce.
  task automatic expect_packet(input logic [31:0] n);
    logic [7:0] b[12];
    logic [31:0] c;
    b[0] = 8'h0C; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h06;
    for (int i = 0; i < 4; i++) b[4+i] = n[8*i +: 8];
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) c = crc_step(c, b[i]);
    for (int i = 0; i < 4; i++) b[8+i] = c[8*i +: 8];
    for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
  endtask

  task automatic strobe(input logic [31:0] n);
    rx_golden_nonce = n;
    rx_new_nonce = 1'b1;
    @(posedge clk);
    #2;
    rx_new_nonce = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #2;
      if (!busy && fifo_level == 5'd0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL wait_idle: timeout with %0d bytes still expected, busy=%0d", exp_q.size(), busy);
    end
  endtask

  // tx_ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  // Monitor: decoupled from stimulus; compares every transferred byte against the scoreboard.
  initial begin
    int m_idx;
    logic [31:0] m_crc;
    logic prev_vld, prev_rdy;
    logic [7:0] prev_byte;
    m_idx = 0; m_crc = 32'hFFFFFFFF; prev_vld = 1'b0; prev_rdy = 1'b0; prev_byte = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
        m_idx = 0;
        m_crc = 32'hFFFFFFFF;
        prev_vld = 1'b0;
      end else begin
        if (prev_vld && !prev_rdy) begin
          check("hold_vld", 32'(tx_valid), 32'd1);
          check("hold_byte", 32'(tx_byte), 32'(prev_byte));
        end
        if (m_idx != 0) check("no_gap", 32'(tx_valid), 32'd1);
        if (tx_valid && tx_ready) begin
          if (m_idx == 0) start_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got %h, expected no byte", tx_byte);
          end else begin
            check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
          end
          m_crc = crc_step(m_crc, tx_byte);
          m_idx++;
          if (m_idx == 12) begin
            check("crc_residue", m_crc, 32'h0);
            end_q.push_back(cyc);
            m_idx = 0;
            m_crc = 32'hFFFFFFFF;
          end
        end
        prev_vld = tx_valid;
        prev_rdy = tx_ready;
        prev_byte = tx_byte;
      end
    end
  end

  initial begin
    logic [31:0] n, a;
    int k;

    // Reset values.
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow_count), 32'd0);
    reset_n = 1'b1;

    // Single nonce on the first edge after reset release, minimum latency and 12 consecutive bytes.
    start_q.delete(); end_q.delete();
    expect_packet(32'h12345678);
    strobe(32'h12345678);
    check("lat_idle_valid", 32'(tx_valid), 32'd0);
    check("lat_idle_level", 32'(fifo_level), 32'd1);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(tx_valid), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_level", 32'(fifo_level), 32'd0);
    check("lat_byte0", 32'(tx_byte), 32'h0C);
    wait_idle(200);
    check("single_pkts", 32'(start_q.size()), 32'd1);
    if (start_q.size() == 1 && end_q.size() == 1)
      check("single_len", 32'(end_q[0] - start_q[0]), 32'd11);

    // Random bursts under 30% backpressure; bursts never exceed the queue so nothing drops.
    ready_mode = 2;
    for (int b = 0; b < 15; b++) begin
      k = $urandom_range(1, DEPTH);
      for (int j = 0; j < k; j++) begin
        n = $urandom;
        expect_packet(n);
        strobe(n);
      end
      wait_idle(5000);
    end
    check("rand_overflow", 32'(overflow_count), 32'd0);

    // Overflow while stalled: one in flight, four queued, sixth dropped.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 6; i++) begin
      n = $urandom;
      if (i < 5) expect_packet(n);
      strobe(n);
    end
    repeat (2) @(posedge clk);
    #2;
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_count", 32'(overflow_count), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    check("ovf_byte0", 32'(tx_byte), 32'h0C);
    ready_mode = 1;
    wait_idle(500);

    // Saturation: 300 strobes while stalled, 295 dropped on top of the earlier one.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 300; i++) begin
      n = $urandom;
      if (i < 5) expect_packet(n);
      strobe(n);
    end
    check("sat_count", 32'(overflow_count), 32'hFF);
    check("sat_level", 32'(fifo_level), 32'd4);
    ready_mode = 1;
    wait_idle(500);
    check("sat_drained", 32'(fifo_level), 32'd0);
    check("sat_hold", 32'(overflow_count), 32'hFF);

    // Back-to-back: three packets separated by exactly one idle cycle.
    repeat (2) @(posedge clk);
    #2;
    start_q.delete(); end_q.delete();
    for (int i = 0; i < 3; i++) begin
      n = $urandom;
      expect_packet(n);
      strobe(n);
    end
    wait_idle(500);
    check("b2b_pkts", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3 && end_q.size() == 3) begin
      for (int i = 0; i < 3; i++) check("b2b_len", 32'(end_q[i] - start_q[i]), 32'd11);
      for (int i = 0; i < 2; i++) check("b2b_gap", 32'(start_q[i+1] - end_q[i]), 32'd2);
    end
    check("b2b_level", 32'(fifo_level), 32'd0);

    // Reset mid-packet after byte 5 with two nonces queued.
    a = $urandom;
    expect_packet(a);
    strobe(a);
    for (int i = 0; i < 2; i++) begin
      n = $urandom;
      expect_packet(n);
      strobe(n);
    end
    repeat (5) @(posedge clk);
    #1;
    check("mid_byte6", 32'(tx_byte), 32'(a[23:16]));
    check("mid_level", 32'(fifo_level), 32'd2);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_tx_byte", 32'(tx_byte), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_overflow", 32'(overflow_count), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_quiet", 32'(tx_valid), 32'd0);
    end
    check("post_rst_level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
